axi_lite_regfile: RTL and testbench
===================================

// Module: axi_lite_regfile
// PURPOSE
//  AXI-Lite responder (slave) backed by a bank of 32-bit registers; the far end of the core's
//  AXI-Lite master bridge. Holds control/config registers for the Ethernet datapath.
//  Some registers are read-only and reflect live hardware status inputs.
//  Every accepted access gets one response; at most one write and one read outstanding.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  byte address of register 0; must be 4*N_REGS aligned
//  N_REGS     16             number of 32-bit registers, 1..256
//  RO_MASK    16'h0000       bit i=1: reg i read-only, reads return status_i word i
// PORTS
//  clk         in   1            single clock, all logic rising-edge
//  resetn      in   1            asynchronous active-low reset
//  s_axi       ---  AXI_LITE.slave   aw*/w*/b*/ar*/r* channels; awprot/arprot ignored
//  status_i    in   32*N_REGS    hardware status words; word i = bits [32*i+31:32*i]
//  regs_o      out  32*N_REGS    current register contents; word i as above
//  wr_pulse_o  out  N_REGS       1-cycle pulse on the cycle after a write commits to reg i
// BEHAVIOUR
//  Reset (async assert, sync release): regs_o=0, wr_pulse_o=0, bvalid=rvalid=0,
//   bresp=rresp=2'b00, rdata=0, AW/W holding registers empty.
//  Ready signals are decoded from state: awready=!aw_full&!bvalid; wready=!w_full&!bvalid;
//   arready=!rvalid. All three read 1 immediately after reset.
//  Decode: off=addr-BASE_ADDR; in range iff addr>=BASE_ADDR and off<4*N_REGS; idx=off[..:2];
//   addr[1:0] ignored.
//  Write channel: AW and W accepted independently, any order or same cycle; each latched into
//   a holding register (aw_full/w_full). Commit on the cycle both are available (held or
//   handshaking now). At that edge:
//   - target reg updated byte-wise per wstrb (byte k written iff wstrb[k]);
//   - bvalid=1; bresp=OKAY;
//   - bresp=SLVERR(2'b10), no reg change if out of range or RO_MASK[idx];
//   - holding regs cleared.
//   wstrb=0 in range: OKAY, no change, still pulses.
//   wr_pulse_o[idx]=1 for exactly the cycle bvalid first rises, valid writes only.
//   bvalid holds with bresp stable until bready; the handshake edge clears bvalid.
//   New AW/W can be accepted the following cycle.
//  Read channel: AR handshake edge samples the reg (or status_i word if RO) into rdata.
//   Sets rvalid=1 and rresp=OKAY. Latency = 1 cycle. Out of range: rdata=0, rresp=SLVERR.
//   rvalid/rdata/rresp hold stable until rready; arready=0 while rvalid.
//  Read/write of the same reg in one cycle: read returns the pre-write value.
//   Read and write paths are fully independent.
//  No AXI combinational loops: no ready depends on the same-cycle valid of its own channel.
//  Reset mid-transaction: all pending AW/W/B/R state is dropped; no response is issued.
// STRUCTURE
//  axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, typedef axi_resp_t.
//   The core-side bridge uses the same package.
//  Sub-module axi_lite_addr_decode: comb; addr -> {hit, idx, ro}; reused by other responders.
//  Top holds the AW/W holding regs, B/R state, reg array and pulse logic.
// TESTING
//  Program: BASE_ADDR=32'h4000_0000, N_REGS=16, RO_MASK=16'h0008.
//  1 Single write: AW 0x4000_0004 with W 0xDEADBEEF, wstrb F, same cycle ->
//    bvalid next cycle, OKAY, regs_o[1]=DEADBEEF, wr_pulse_o[1] high 1 cycle.
//    Then read 0x4000_0004 -> rdata DEADBEEF, rvalid 1 cycle after AR.
//  2 Split order + strobe: W 0x11223344 wstrb 4'b0101 three cycles before AW 0x4000_0008.
//    Reg2 starts at 0 -> reg2=0x00220044; bvalid only after AW arrives;
//    awready/wready low while bvalid pending.
//  3 Errors: write 0x4000_0040 (out of range) -> SLVERR, no reg change, no pulse.
//    Write reg3 (RO) -> SLVERR. Read reg3 with status_i word3=0xCAFE0001 -> OKAY, 0xCAFE0001.
//  4 Backpressure: hold bready=0 / rready=0 for 5 cycles -> bvalid/rvalid, resp and rdata
//    stable; arready=0 throughout; each completes exactly once.
//  5 Collision: reg5=0xA, same cycle AR 0x4000_0014 and AW+W 0x4000_0014 = 0xB ->
//    rdata=0xA, then reg5=0xB.
//  6 Reset mid-op: assert resetn=0 with AW held and bvalid=0 -> all outputs at reset values.
//    After release, the first write completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and a register-index width helper.
// Used by the register file and by the core-side master bridge.
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Number of index bits needed to address n registers (never less than 1).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder for a word-addressed register window.
// Maps a byte address to {hit, register index, read-only flag}; addr[1:0] are ignored.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int N_REGS = 16,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  localparam int IDX_W = idx_width(N_REGS)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic             ro
);

  localparam logic [31:0] SPAN = 32'(4 * N_REGS);

  logic [31:0] off;

  // Window check, word index extraction and read-only lookup.
  always_comb begin
    off = addr - BASE_ADDR;
    hit = (addr >= BASE_ADDR) && (off < SPAN);
    idx = off[IDX_W+1:2];
    ro  = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == IDX_W'(i)) ro = hit & RO_MASK[i];
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite responder backed by N_REGS 32-bit registers. Read-only registers return live
// status words. One write and one read may be outstanding; read and write paths are
// independent, and a same-cycle read of a register being written returns the old value.
// Handshake: a transfer happens on a rising edge where valid && ready; every ready is
// decoded from registered state only, never from the same channel's valid.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int N_REGS = 16,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  localparam int IDX_W = idx_width(N_REGS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [32*N_REGS-1:0]  status_i,
  output logic [32*N_REGS-1:0]  regs_o,
  output logic [N_REGS-1:0]     wr_pulse_o
);

  logic             aw_full, w_full;
  logic [31:0]      aw_addr_q, w_data_q;
  logic [3:0]       w_strb_q;
  logic [31:0]      regs     [N_REGS];
  logic [31:0]      status_w [N_REGS];

  logic             aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [31:0]      wr_addr, wr_data, rd_word;
  logic [3:0]       wr_strb;
  logic             wr_hit, wr_ro, rd_hit, rd_ro;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  assign s_axi_awready = !aw_full && !s_axi_bvalid;
  assign s_axi_wready  = !w_full && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  // Commit as soon as both halves are present, whether held or arriving this cycle.
  assign commit = (aw_full || aw_hs) && (w_full || w_hs) && !s_axi_bvalid;

  assign wr_addr = aw_full ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_full ? w_data_q : s_axi_wdata;
  assign wr_strb = w_full ? w_strb_q : s_axi_wstrb;
  assign wr_ok   = wr_hit && !wr_ro;

  for (genvar i = 0; i < N_REGS; i++) begin : g_words
    assign regs_o[32*i +: 32] = regs[i];
    assign status_w[i]        = status_i[32*i +: 32];
  end

  axi_lite_addr_decode #(.BASE_ADDR(BASE_ADDR), .N_REGS(N_REGS), .RO_MASK(RO_MASK)) u_wr_dec (
    .addr(wr_addr), .hit(wr_hit), .idx(wr_idx), .ro(wr_ro)
  );

  axi_lite_addr_decode #(.BASE_ADDR(BASE_ADDR), .N_REGS(N_REGS), .RO_MASK(RO_MASK)) u_rd_dec (
    .addr(s_axi_araddr), .hit(rd_hit), .idx(rd_idx), .ro(rd_ro)
  );

  // Read source: live status for read-only registers, zero outside the window.
  always_comb begin
    rd_word = '0;
    if (rd_hit) rd_word = rd_ro ? status_w[rd_idx] : regs[rd_idx];
  end

  // AW/W holding registers and the B channel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  // Register array byte-lane update and the one-cycle write pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit && wr_ok) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
        wr_pulse_o[wr_idx] <= 1'b1;
      end
    end
  end

  // R channel: sample on the AR handshake, hold until rready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: a vector table of single transactions followed by
// hand-written sequences for split AW/W order, backpressure, read/write collision and
// reset in the middle of a transaction.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int N = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [N-1:0] RO = 16'h0008;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [32*N-1:0] status_i, regs_o;
  logic [N-1:0] wr_pulse_o;

  axi_lite_regfile #(.BASE_ADDR(BASE), .N_REGS(N), .RO_MASK(RO)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .status_i(status_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] model [N];

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] pulse;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return regs_o[32*i +: 32];
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s reg%0d", tag, i), reg_word(i), model[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive AW and W together; ok=1 only if bvalid is up right after the commit edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse, output logic ok);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      logic a_hs, d_hs;
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      step();
      n++;
      if (a_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (d_hs) begin wvalid = 1'b0; w_done = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    ok = aw_done && w_done && bvalid;
    resp = bresp;
    pulse = wr_pulse_o;
    step();
  endtask

  // Drive AR; ok=1 only if rvalid is up one cycle after the handshake edge.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output logic ok);
    bit done = 0;
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!done && n < 20) begin
      logic hs;
      hs = arvalid && arready;
      step();
      n++;
      if (hs) begin arvalid = 1'b0; done = 1; end
    end
    arvalid = 1'b0;
    ok = done && rvalid;
    d = rdata;
    r = rresp;
    step();
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] resp;
    logic [15:0] pulse;
    logic [31:0] d;
    logic ok;
    int idx;

    for (int i = 0; i < N; i++) begin
      status_i[32*i +: 32] = (i == 3) ? 32'hCAFE_0001 : {16'h5A5A, 16'(i)};
      model[i] = '0;
    end

    vecs[0]  = '{1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0, 16'h0002};
    vecs[1]  = '{1'b0, 32'h4000_0004, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF, 16'h0};
    vecs[2]  = '{1'b1, 32'h4000_0040, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0, 16'h0000};
    vecs[3]  = '{1'b1, 32'h4000_000C, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0, 16'h0000};
    vecs[4]  = '{1'b0, 32'h4000_000C, 32'h0,         4'h0, RESP_OKAY,   32'hCAFE_0001, 16'h0};
    vecs[5]  = '{1'b0, 32'h4000_0040, 32'h0,         4'h0, RESP_SLVERR, 32'h0, 16'h0};
    vecs[6]  = '{1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0, RESP_SLVERR, 32'h0, 16'h0};
    vecs[7]  = '{1'b1, 32'h4000_003C, 32'hFFFF_FFFF, 4'h8, RESP_OKAY,   32'h0, 16'h8000};
    vecs[8]  = '{1'b0, 32'h4000_003F, 32'h0,         4'h0, RESP_OKAY,   32'hFF00_0000, 16'h0};
    vecs[9]  = '{1'b1, 32'h4000_0018, 32'h0000_0055, 4'h0, RESP_OKAY,   32'h0, 16'h0040};
    vecs[10] = '{1'b0, 32'h4000_0018, 32'h0,         4'h0, RESP_OKAY,   32'h0, 16'h0};
    vecs[11] = '{1'b0, 32'h4000_0020, 32'h0,         4'h0, RESP_OKAY,   32'h0, 16'h0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst bvalid", bvalid, 0);
    check("rst rvalid", rvalid, 0);
    check("rst rdata", rdata, 0);
    check("rst pulse", wr_pulse_o, 0);
    check("rst readies", {awready, wready, arready}, 3'b111);
    check_all_regs("rst");
    resetn = 1'b1;
    step();

    // Vector table.
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse, ok);
        check($sformatf("v%0d b_latency", v), ok, 1);
        check($sformatf("v%0d bresp", v), resp, vecs[v].resp);
        check($sformatf("v%0d wr_pulse", v), pulse, vecs[v].pulse);
        check($sformatf("v%0d b_clear", v), {wr_pulse_o, bvalid}, 0);
        if (vecs[v].resp == RESP_OKAY) begin
          idx = int'((vecs[v].addr - BASE) >> 2);
          for (int k = 0; k < 4; k++)
            if (vecs[v].strb[k]) model[idx][8*k +: 8] = vecs[v].data[8*k +: 8];
        end
        check_all_regs($sformatf("v%0d", v));
      end else begin
        do_read(vecs[v].addr, d, resp, ok);
        check($sformatf("v%0d r_latency", v), ok, 1);
        check($sformatf("v%0d rresp", v), resp, vecs[v].resp);
        check($sformatf("v%0d rdata", v), d, vecs[v].rdata);
        check($sformatf("v%0d r_clear", v), rvalid, 0);
      end
    end

    // W three cycles ahead of AW, with a partial strobe.
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
    check("split wready", wready, 1);
    step();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("split wait%0d bvalid", c), bvalid, 0);
      check($sformatf("split wait%0d wready", c), wready, 0);
      check($sformatf("split wait%0d awready", c), awready, 1);
      step();
    end
    awaddr = 32'h4000_0008; awvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0;
    check("split bvalid", bvalid, 1);
    check("split bresp", bresp, RESP_OKAY);
    check("split pulse", wr_pulse_o, 16'h0004);
    check("split readies", {awready, wready}, 2'b00);
    check("split reg2", reg_word(2), 32'h0022_0044);
    step();
    check("split hold bvalid", bvalid, 1);
    check("split hold readies", {awready, wready}, 2'b00);
    check("split hold pulse", wr_pulse_o, 0);
    bready = 1'b1;
    step();
    check("split done bvalid", bvalid, 0);
    check("split done readies", {awready, wready}, 2'b11);
    model[2] = 32'h0022_0044;

    // Backpressure on both response channels.
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h4000_0010; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 32'h4000_0004;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    check("bp arready", arready, 1);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d bvalid", c), bvalid, 1);
      check($sformatf("bp%0d bresp", c), bresp, RESP_OKAY);
      check($sformatf("bp%0d rvalid", c), rvalid, 1);
      check($sformatf("bp%0d rdata", c), rdata, 32'hDEAD_BEEF);
      check($sformatf("bp%0d rresp", c), rresp, RESP_OKAY);
      check($sformatf("bp%0d arready", c), arready, 0);
      check($sformatf("bp%0d awready", c), awready, 0);
      check($sformatf("bp%0d pulse", c), wr_pulse_o, (c == 0) ? 16'h0010 : 16'h0000);
      step();
    end
    bready = 1'b1; rready = 1'b1;
    step();
    check("bp done valids", {bvalid, rvalid}, 2'b00);
    step();
    check("bp once valids", {bvalid, rvalid}, 2'b00);
    model[4] = 32'h0BAD_F00D;
    check_all_regs("bp");

    // Same-cycle read and write of one register.
    do_write(32'h4000_0014, 32'h0000_000A, 4'hF, resp, pulse, ok);
    check("col pre bresp", resp, RESP_OKAY);
    model[5] = 32'h0000_000A;
    awaddr = 32'h4000_0014; wdata = 32'h0000_000B; wstrb = 4'hF; araddr = 32'h4000_0014;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("col rvalid", rvalid, 1);
    check("col rdata", rdata, 32'h0000_000A);
    check("col bvalid", bvalid, 1);
    check("col reg5", reg_word(5), 32'h0000_000B);
    step();
    check("col done valids", {bvalid, rvalid}, 2'b00);

    // Reset with AW held and a read response pending.
    rready = 1'b0;
    awaddr = 32'h4000_001C; awvalid = 1'b1; araddr = 32'h4000_0004; arvalid = 1'b1;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    check("mid bvalid", bvalid, 0);
    check("mid awready", awready, 0);
    check("mid rvalid", rvalid, 1);
    resetn = 1'b0;
    #1;
    check("mid rst bvalid", bvalid, 0);
    check("mid rst rvalid", rvalid, 0);
    check("mid rst rdata", rdata, 0);
    check("mid rst resps", {bresp, rresp}, 0);
    check("mid rst pulse", wr_pulse_o, 0);
    check("mid rst readies", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < N; i++) model[i] = '0;
    check_all_regs("mid rst");
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("post rst aw dropped", bvalid, 0);
    step();
    check("post rst still idle", bvalid, 0);
    awaddr = 32'h4000_001C; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("post rst bvalid", bvalid, 1);
    check("post rst bresp", bresp, RESP_OKAY);
    check("post rst pulse", wr_pulse_o, 16'h0080);
    step();
    model[7] = 32'h0000_0077;
    check_all_regs("post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
